// File: rtl/line_buffer_5row_pkg.sv
// rtl/line_buffer_5row_pkg.sv - shared pixel width and FSM encoding for the 5-row line buffer
package line_buffer_5row_pkg;

  localparam int BIT_LENGTH = 5;
  localparam int FILL_ROWS  = 4;

  typedef logic [BIT_LENGTH-1:0] pixel_t;

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/line_buffer_5row_if.sv
// rtl/line_buffer_5row_if.sv - raster pixel input and 5-pixel column output bundle
interface line_buffer_5row_if;

  logic                         in_valid;
  line_buffer_5row_pkg::pixel_t pixel_in;
  line_buffer_5row_pkg::pixel_t pixel_out0;
  line_buffer_5row_pkg::pixel_t pixel_out1;
  line_buffer_5row_pkg::pixel_t pixel_out2;
  line_buffer_5row_pkg::pixel_t pixel_out3;
  line_buffer_5row_pkg::pixel_t pixel_out4;
  logic                         enable;
  logic                         frame_done;
  logic                         stall_err;

  modport master (
    output in_valid, pixel_in,
    input  pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4,
    input  enable, frame_done, stall_err
  );

  modport slave (
    input  in_valid, pixel_in,
    output pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4,
    output enable, frame_done, stall_err
  );

endinterface

// File: rtl/line_buffer_5row_line_mem.sv
// rtl/line_buffer_5row_line_mem.sv - one image line of storage, combinational read-before-write
module line_mem
  import line_buffer_5row_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  pixel_t                   wdata,
  output pixel_t                   rdata
);

  // Deliberately unreset: the FILL phase rewrites every entry before it is read.
  pixel_t mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/line_buffer_5row.sv
// rtl/line_buffer_5row.sv - raster-to-column converter feeding the 5x5 Gaussian filter
module line_buffer_5row
  import line_buffer_5row_pkg::*;
#(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input logic                clk,
  input logic                reset,
  line_buffer_5row_if.slave  bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] FILL_LAST = RW'(FILL_ROWS - 1);

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_wrap;
  pixel_t        rd0, rd1, rd2, rd3;
  pixel_t        out0, out1, out2, out3, out4;
  logic          enable_q, stall_q;

  assign accept   = bus.in_valid && (state != DONE);
  assign col_wrap = (col == COL_LAST);

  // lb0 holds row r-1 ... lb3 holds row r-4; each shifts its old entry down one memory.
  line_mem #(.DEPTH(IMG_WIDTH)) u_lb0 (.clk(clk), .we(accept), .addr(col), .wdata(bus.pixel_in), .rdata(rd0));
  line_mem #(.DEPTH(IMG_WIDTH)) u_lb1 (.clk(clk), .we(accept), .addr(col), .wdata(rd0),          .rdata(rd1));
  line_mem #(.DEPTH(IMG_WIDTH)) u_lb2 (.clk(clk), .we(accept), .addr(col), .wdata(rd1),          .rdata(rd2));
  line_mem #(.DEPTH(IMG_WIDTH)) u_lb3 (.clk(clk), .we(accept), .addr(col), .wdata(rd2),          .rdata(rd3));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FILL;
      col      <= '0;
      row      <= '0;
      out0     <= '0;
      out1     <= '0;
      out2     <= '0;
      out3     <= '0;
      out4     <= '0;
      enable_q <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      if (state == STREAM && !bus.in_valid) stall_q <= 1'b1;
      if (accept) begin
        out4 <= bus.pixel_in;
        out3 <= rd0;
        out2 <= rd1;
        out1 <= rd2;
        out0 <= rd3;
        col  <= col_wrap ? '0 : col + CW'(1);
        if (col_wrap) row <= row + RW'(1);
        if (state == STREAM) begin
          enable_q <= 1'b1;
          if (col_wrap && row == ROW_LAST) state <= DONE;
        end else begin
          enable_q <= 1'b0;
          if (col_wrap && row == FILL_LAST) state <= STREAM;
        end
      end else begin
        enable_q <= 1'b0;
      end
    end
  end

  assign bus.pixel_out0 = out0;
  assign bus.pixel_out1 = out1;
  assign bus.pixel_out2 = out2;
  assign bus.pixel_out3 = out3;
  assign bus.pixel_out4 = out4;
  assign bus.enable     = enable_q;
  assign bus.frame_done = (state == DONE);
  assign bus.stall_err  = stall_q;

endmodule
